// File: rtl/npu_fetch_pkg.sv
// Shared widths, FSM state codes and the return-buffer entry layout for the instruction fetcher.
package npu_fetch_pkg;

  localparam int NPU_ADDR_W = 8;
  localparam int NPU_DATA_W = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [NPU_ADDR_W-1:0] addr;
    logic [NPU_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/npu_fetch_fifo.sv
// Synchronous show-ahead FIFO: the head entry sits on pop_dat whenever not empty.
// Latency: a pushed entry is visible on pop_dat the following cycle.
// Backpressure: full is reported to the writer; a push while full without a pop is a design error.
module npu_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full && !do_pop));
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/npu_inst_fetch.sv
// Avalon-MM read master streaming instruction words from SRAM port s2 to the NPU decoder.
// Latency: first read 1 cycle after start, first inst_valid 3 cycles after start; 1 word/cycle unstalled.
// Backpressure: a read is issued only while buffered plus in-flight words leave room in the return FIFO.
module npu_inst_fetch
  import npu_fetch_pkg::*;
#(
  parameter int ADDR_W       = NPU_ADDR_W,
  parameter int DATA_W       = NPU_DATA_W,
  parameter int BE_W         = DATA_W / 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   inst_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic [DATA_W-1:0] sram_writedata,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] REM_ONE = 1;

  logic [1:0]              state;
  logic [ADDR_W:0]         remaining;
  logic [ADDR_W-1:0]       addr_q;
  logic                    aborting;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [ADDR_W-1:0]       tag_addr [READ_LATENCY];
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    issue;
  logic                    abort_now;
  logic                    push;
  logic                    pop;
  logic                    drained;
  int                      inflight;
  fetch_entry_t            push_entry;
  fetch_entry_t            head;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + int'(tag_vld[i]);
  end

  // The pop of the current cycle is deliberately not credited when deciding to issue.
  assign abort_now = abort && (state == ST_FETCH || state == ST_DRAIN);
  assign issue     = (state == ST_FETCH) && !abort && (remaining != '0) && !fifo_full &&
                     ((int'(fifo_count) + inflight) < FIFO_DEPTH);
  assign push      = tag_vld[READ_LATENCY-1] && !aborting && !abort_now;
  assign pop       = !fifo_empty && inst_ready;
  assign drained   = (inflight == 0) && (fifo_empty || (fifo_count == CNT_W'(1) && pop));

  assign push_entry.addr = tag_addr[READ_LATENCY-1];
  assign push_entry.data = sram_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      addr_q    <= '0;
      aborting  <= 1'b0;
      tag_vld   <= '0;
    end else begin
      tag_vld[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) tag_vld[i] <= tag_vld[i-1];
      case (state)
        ST_IDLE: if (start) begin
          if (inst_count != '0) begin
            state     <= ST_FETCH;
            addr_q    <= start_addr;
            remaining <= inst_count;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_FETCH: if (abort) begin
          state    <= ST_DRAIN;
          aborting <= 1'b1;
        end else if (issue) begin
          addr_q    <= addr_q + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == REM_ONE) state <= ST_DRAIN;
        end
        ST_DRAIN: if (abort || aborting) begin
          aborting <= 1'b1;
          if (inflight == 0) state <= ST_DONE;
        end else if (drained) begin
          state <= ST_DONE;
        end
        default: begin
          state    <= ST_IDLE;
          aborting <= 1'b0;
        end
      endcase
    end
  end

  // Address tags need no reset: they are only consumed alongside a valid bit.
  always_ff @(posedge clk) begin
    tag_addr[0] <= addr_q;
    for (int i = 1; i < READ_LATENCY; i++) tag_addr[i] <= tag_addr[i-1];
  end

  npu_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (abort_now),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign busy            = (state == ST_FETCH) || (state == ST_DRAIN);
  assign done            = (state == ST_DONE);
  assign sram_address    = addr_q;
  assign sram_chipselect = issue;
  assign sram_write      = 1'b0;
  assign sram_byteenable = '1;
  assign sram_writedata  = '0;
  assign inst_valid      = !fifo_empty;
  assign inst_data       = head.data;
  assign inst_addr       = head.addr;

endmodule

// File: tb/tb_npu_inst_fetch.sv
// Self-checking bench for npu_inst_fetch: random SRAM contents and ready patterns against a sequence model.
module tb_npu_inst_fetch;

  localparam int MAXC  = 520;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset, start, abort, inst_ready;
  logic [7:0]   start_addr;
  logic [8:0]   inst_count;
  logic         busy, done, sram_chipselect, sram_write, inst_valid;
  logic [7:0]   sram_address, inst_addr;
  logic [15:0]  sram_byteenable;
  logic [127:0] sram_writedata, sram_readdata, inst_data;
  logic [127:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic         t_cs [MAXC];
  logic [7:0]   t_sa [MAXC];
  logic         t_v [MAXC];
  logic         t_r [MAXC];
  logic         t_done [MAXC];
  logic         t_busy [MAXC];
  logic [127:0] t_d [MAXC];
  logic [7:0]   t_ia [MAXC];

  int           cs_c[$];
  int           pop_c[$];
  int           done_c[$];
  logic [7:0]   cs_a[$];
  logic [7:0]   pop_a[$];
  logic [127:0] pop_d[$];

  always #5 clk = ~clk;

  // SRAM s2: one-cycle read latency; garbage when not selected to expose mistimed captures.
  always @(posedge clk)
    sram_readdata <= sram_chipselect ? mem[sram_address] : {$urandom(), $urandom(), $urandom(), $urandom()};

  npu_inst_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_addr      (start_addr),
    .inst_count      (inst_count),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_writedata  (sram_writedata),
    .sram_readdata   (sram_readdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_addr       (inst_addr)
  );

  task automatic collect(input int ncyc);
    cs_c.delete(); cs_a.delete(); pop_c.delete(); pop_a.delete(); pop_d.delete(); done_c.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (t_cs[c]) begin cs_c.push_back(c); cs_a.push_back(t_sa[c]); end
      if (t_v[c] && t_r[c]) begin pop_c.push_back(c); pop_d.push_back(t_d[c]); pop_a.push_back(t_ia[c]); end
      if (t_done[c]) done_c.push_back(c);
    end
  endtask

  // Entered #1 after a rising edge; cycle 0 carries the start request.
  task automatic run(input logic [7:0] a, input int n, input int rmode, input int abort_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start      = (c == 0);
      start_addr = a;
      inst_count = n[8:0];
      abort      = (c == abort_at);
      case (rmode)
        0:       inst_ready = 1'b1;
        1:       inst_ready = (c % 2 == 0);
        default: inst_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      t_cs[c] = sram_chipselect; t_sa[c] = sram_address; t_v[c] = inst_valid; t_r[c] = inst_ready;
      t_done[c] = done; t_busy[c] = busy; t_d[c] = inst_data; t_ia[c] = inst_addr;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; inst_ready = 1'b0;
    collect(ncyc);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; inst_ready = 1'b0; start_addr = '0; inst_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, sram_chipselect, inst_valid} !== 4'b0) begin errors++;
      $display("FAIL reset_ctrl got busy/done/cs/valid=%b want 0000", {busy, done, sram_chipselect, inst_valid}); end
    checks++; if (sram_address !== 8'h00) begin errors++; $display("FAIL reset_sram_address got %h want 00", sram_address); end
    checks++; if (inst_data !== 128'h0) begin errors++; $display("FAIL reset_inst_data got %h want 0", inst_data); end
    checks++; if (inst_addr !== 8'h00) begin errors++; $display("FAIL reset_inst_addr got %h want 00", inst_addr); end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] a = 8'h10;
    logic busy_ok = 1'b1;
    run(a, 4, 0, -1, 12);
    checks++; if (cs_c.size() != 4) begin errors++; $display("FAIL basic_cs_count got %0d want 4", cs_c.size()); end
    for (int k = 0; k < cs_c.size() && k < 4; k++) begin
      checks++; if (cs_c[k] != k + 1 || cs_a[k] !== 8'(a + k)) begin errors++;
        $display("FAIL basic_cs[%0d] got cycle %0d addr %h want cycle %0d addr %h", k, cs_c[k], cs_a[k], k + 1, 8'(a + k)); end
    end
    checks++; if (pop_c.size() != 4) begin errors++; $display("FAIL basic_pop_count got %0d want 4", pop_c.size()); end
    for (int k = 0; k < pop_c.size() && k < 4; k++) begin
      checks++; if (pop_c[k] != k + 3 || pop_d[k] !== mem[8'(a + k)] || pop_a[k] !== 8'(a + k)) begin errors++;
        $display("FAIL basic_word[%0d] got cycle %0d addr %h data %h want cycle %0d addr %h data %h",
                 k, pop_c[k], pop_a[k], pop_d[k], k + 3, 8'(a + k), mem[8'(a + k)]); end
    end
    checks++; if (done_c.size() != 1 || done_c[0] != 7) begin errors++;
      $display("FAIL basic_done got %0d pulses first at %0d want 1 pulse at 7", done_c.size(), done_c.size() ? done_c[0] : -1); end
    for (int c = 1; c <= 6; c++) if (t_busy[c] !== 1'b1) busy_ok = 1'b0;
    if (t_busy[7] !== 1'b0) busy_ok = 1'b0;
    checks++; if (!busy_ok) begin errors++; $display("FAIL basic_busy got wrong busy window want high 1..6 low at 7"); end
    checks++; if (sram_write !== 1'b0 || sram_byteenable !== 16'hFFFF || sram_writedata !== 128'h0) begin errors++;
      $display("FAIL tied_outputs got write=%b be=%h wdata=%h want 0/ffff/0", sram_write, sram_byteenable, sram_writedata); end
  endtask

  task automatic test_wrap();
    logic [7:0] a = 8'hFE;
    run(a, 4, 0, -1, 12);
    checks++; if (cs_c.size() != 4 || pop_c.size() != 4) begin errors++;
      $display("FAIL wrap_counts got cs %0d pops %0d want 4 4", cs_c.size(), pop_c.size()); end
    for (int k = 0; k < 4 && k < cs_c.size() && k < pop_c.size(); k++) begin
      checks++; if (cs_a[k] !== 8'(a + k) || pop_a[k] !== 8'(a + k) || pop_d[k] !== mem[8'(a + k)]) begin errors++;
        $display("FAIL wrap[%0d] got rd %h inst_addr %h want %h", k, cs_a[k], pop_a[k], 8'(a + k)); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a = 8'h40;
    int issued = 0, popped = 0, viol = 0;
    run(a, 8, 1, -1, 40);
    for (int c = 0; c < 40; c++) begin
      if (t_cs[c]) issued++;
      if (issued - popped > DEPTH) viol++;
      if (t_v[c] && t_r[c]) popped++;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL bp_outstanding got %0d cycles over depth want 0", viol); end
    checks++; if (pop_c.size() != 8) begin errors++; $display("FAIL bp_pop_count got %0d want 8", pop_c.size()); end
    for (int k = 0; k < pop_c.size() && k < 8; k++) begin
      checks++; if (pop_a[k] !== 8'(a + k) || pop_d[k] !== mem[8'(a + k)]) begin errors++;
        $display("FAIL bp_word[%0d] got addr %h want %h", k, pop_a[k], 8'(a + k)); end
    end
    for (int c = 0; c < 39; c++) if (t_v[c] && !t_r[c]) begin
      checks++; if (t_v[c+1] !== 1'b1 || t_d[c+1] !== t_d[c] || t_ia[c+1] !== t_ia[c]) begin errors++;
        $display("FAIL bp_stall_hold cycle %0d got addr %h want %h", c + 1, t_ia[c+1], t_ia[c]); end
    end
    checks++; if (done_c.size() != 1 || pop_c.size() == 0 || done_c[0] != pop_c[pop_c.size()-1] + 1) begin errors++;
      $display("FAIL bp_done got %0d pulses want 1 right after last word", done_c.size()); end
  endtask

  task automatic test_zero();
    logic any_busy = 1'b0;
    run(8'h22, 0, 0, -1, 6);
    for (int c = 0; c < 6; c++) if (t_busy[c]) any_busy = 1'b1;
    checks++; if (cs_c.size() != 0) begin errors++; $display("FAIL zero_cs got %0d reads want 0", cs_c.size()); end
    checks++; if (done_c.size() != 1 || done_c[0] != 1) begin errors++;
      $display("FAIL zero_done got %0d pulses first at %0d want 1 at 1", done_c.size(), done_c.size() ? done_c[0] : -1); end
    checks++; if (any_busy) begin errors++; $display("FAIL zero_busy got 1 want 0"); end
  endtask

  task automatic test_abort();
    logic [7:0] a = 8'($urandom_range(0, 255));
    logic [7:0] b = 8'($urandom_range(0, 255));
    int late_cs = 0, late_v = 0;
    run(a, 16, 0, 5, 30);
    for (int c = 5; c < 30; c++) if (t_cs[c]) late_cs++;
    for (int c = 6; c < 30; c++) if (t_v[c]) late_v++;
    checks++; if (late_cs != 0 || cs_c.size() != 4) begin errors++;
      $display("FAIL abort_cs got %0d reads (%0d late) want 4 (0 late)", cs_c.size(), late_cs); end
    checks++; if (late_v != 0) begin errors++; $display("FAIL abort_valid got %0d valid cycles after abort want 0", late_v); end
    checks++; if (done_c.size() != 1) begin errors++; $display("FAIL abort_done got %0d pulses want 1", done_c.size()); end
    for (int k = 0; k < pop_c.size(); k++) begin
      checks++; if (pop_a[k] !== 8'(a + k) || pop_d[k] !== mem[8'(a + k)]) begin errors++;
        $display("FAIL abort_word[%0d] got addr %h want %h", k, pop_a[k], 8'(a + k)); end
    end
    run(b, 5, 0, -1, 15);
    checks++; if (pop_c.size() != 5 || done_c.size() != 1) begin errors++;
      $display("FAIL abort_restart got %0d words %0d done want 5 1", pop_c.size(), done_c.size()); end
    for (int k = 0; k < pop_c.size() && k < 5; k++) begin
      checks++; if (pop_a[k] !== 8'(b + k) || pop_d[k] !== mem[8'(b + k)]) begin errors++;
        $display("FAIL abort_restart_word[%0d] got addr %h want %h", k, pop_a[k], 8'(b + k)); end
    end
  endtask

  task automatic test_full_memory();
    int bad_cs = 0, bad_pop = 0;
    run(8'h00, 256, 0, -1, 262);
    for (int k = 0; k < cs_c.size(); k++) if (cs_c[k] != k + 1 || cs_a[k] !== 8'(k)) bad_cs++;
    for (int k = 0; k < pop_c.size(); k++) if (pop_c[k] != k + 3 || pop_a[k] !== 8'(k) || pop_d[k] !== mem[k]) bad_pop++;
    checks++; if (cs_c.size() != 256 || bad_cs != 0) begin errors++;
      $display("FAIL full_reads got %0d reads %0d misplaced want 256 0", cs_c.size(), bad_cs); end
    checks++; if (pop_c.size() != 256 || bad_pop != 0) begin errors++;
      $display("FAIL full_words got %0d words %0d wrong want 256 0", pop_c.size(), bad_pop); end
    checks++; if (done_c.size() != 1 || done_c[0] != 259) begin errors++;
      $display("FAIL full_done got %0d pulses first at %0d want 1 at 259", done_c.size(), done_c.size() ? done_c[0] : -1); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] a = 8'($urandom_range(0, 255));
      int n = $urandom_range(1, 40);
      int bad = 0, issued = 0, popped = 0, viol = 0;
      run(a, n, 2, -1, 12 * n + 20);
      for (int k = 0; k < pop_c.size(); k++) if (pop_a[k] !== 8'(a + k) || pop_d[k] !== mem[8'(a + k)]) bad++;
      for (int c = 0; c < 12 * n + 20; c++) begin
        if (t_cs[c]) issued++;
        if (issued - popped > DEPTH) viol++;
        if (t_v[c] && t_r[c]) popped++;
      end
      checks++; if (pop_c.size() != n || bad != 0) begin errors++;
        $display("FAIL rand%0d_words got %0d words %0d wrong want %0d 0", it, pop_c.size(), bad, n); end
      checks++; if (viol != 0 || cs_c.size() != n) begin errors++;
        $display("FAIL rand%0d_issue got %0d reads %0d over depth want %0d 0", it, cs_c.size(), viol, n); end
      checks++; if (done_c.size() != 1 || pop_c.size() == 0 || done_c[0] != pop_c[pop_c.size()-1] + 1) begin errors++;
        $display("FAIL rand%0d_done got %0d pulses want 1 right after last word", it, done_c.size()); end
    end
  endtask

  task automatic test_reset_midrun();
    int dn = 0;
    start = 1'b1; start_addr = 8'h30; inst_count = 9'd20; inst_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) begin @(negedge clk); if (done) dn++; @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); if (done) dn++;
    checks++; if ({busy, sram_chipselect, inst_valid} !== 3'b0 || sram_address !== 8'h00 ||
                  inst_data !== 128'h0 || inst_addr !== 8'h00) begin errors++;
      $display("FAIL midrun_reset_outputs got busy/cs/valid=%b addr=%h iaddr=%h want 000/00/00",
               {busy, sram_chipselect, inst_valid}, sram_address, inst_addr); end
    @(posedge clk); #1; reset = 1'b0;
    repeat (4) begin @(negedge clk); if (done) dn++; @(posedge clk); #1; end
    checks++; if (dn != 0) begin errors++; $display("FAIL midrun_done got %0d pulses want 0", dn); end
    inst_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_abort();
    test_full_memory();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
